// File: rtl/goal_seek_if.sv
// Drive-train goal-seek bus: sensor inputs toward the controller, motor
// direction / duty-select outputs back to the PWM stage.
interface goal_seek_if #(
    parameter int DUTY_W = 2
);
    logic              Enable;
    logic              Pause;
    logic              Inductance;
    logic              IR_1k;
    logic              IR_10k;
    logic              FWD_A;
    logic              FWD_B;
    logic              BWD_A;
    logic              BWD_B;
    logic [DUTY_W-1:0] Duty_SelA;
    logic [DUTY_W-1:0] Duty_SelB;
    logic              Done;
    logic              Fail;
    logic [2:0]        State;

    modport master (
        output Enable, Pause, Inductance, IR_1k, IR_10k,
        input  FWD_A, FWD_B, BWD_A, BWD_B, Duty_SelA, Duty_SelB, Done, Fail, State
    );

    modport slave (
        input  Enable, Pause, Inductance, IR_1k, IR_10k,
        output FWD_A, FWD_B, BWD_A, BWD_B, Duty_SelA, Duty_SelB, Done, Fail, State
    );
endinterface

// File: rtl/goal_seek_ctrl.sv
// Goal-seek direction controller: spin-search for an IR beacon, qualify it,
// run a timed alignment turn, back off from the boundary wire, report Done/Fail.
module goal_seek_ctrl #(
    parameter int DUTY_W         = 2,
    parameter int CNT_W          = 30,
    parameter int ALIGN_CYCLES   = 100_000_000,
    parameter int BACKOFF_CYCLES = 200_000_000,
    parameter int SEARCH_TIMEOUT = 1_000_000_000,
    parameter int QUAL_CYCLES    = 1000,
    parameter bit SEARCH_DIR     = 1'b0,
    parameter int DUTY_SEARCH    = 0,
    parameter int DUTY_ALIGN     = 2,
    parameter int DUTY_BACK      = 3
) (
    input logic        clk,
    input logic        Reset,
    goal_seek_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEARCH  = 3'd1,
        ALIGN_R = 3'd2,
        ALIGN_L = 3'd3,
        PAUSE   = 3'd4,
        BACKOFF = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] ALIGN_LAST = CNT_W'(ALIGN_CYCLES - 1);
    localparam logic [CNT_W-1:0] BACK_MIN   = CNT_W'(BACKOFF_CYCLES);
    localparam logic [CNT_W-1:0] TMR_LIMIT  = CNT_W'(SEARCH_TIMEOUT);
    localparam logic [CNT_W-1:0] QUAL_LIMIT = CNT_W'(QUAL_CYCLES);
    localparam logic [3:0] DRV_R    = 4'b1001;
    localparam logic [3:0] DRV_L    = 4'b0110;
    localparam logic [3:0] DRV_BACK = 4'b0011;
    localparam logic [3:0] DRV_SRCH = SEARCH_DIR ? DRV_L : DRV_R;

    state_t            state, state_nxt, ret, ret_nxt;
    logic [1:0]        en_sr;
    logic              rise;
    logic [CNT_W-1:0]  tmr, tmr_nxt, tmr_inc;
    logic [CNT_W-1:0]  q1, q1_nxt, q1_inc;
    logic [CNT_W-1:0]  q10, q10_nxt, q10_inc;
    logic [CNT_W-1:0]  acnt, acnt_nxt;
    logic [CNT_W-1:0]  bcnt, bcnt_nxt;
    logic              fail, fail_nxt;
    logic [3:0]        drv, drv_nxt;
    logic [DUTY_W-1:0] duty, duty_nxt;
    logic              done;
    logic [2:0]        st_out;

    assign rise = en_sr[0] & ~en_sr[1];

    always_ff @(posedge clk) begin
        if (Reset) begin
            state  <= IDLE;
            ret    <= IDLE;
            en_sr  <= 2'b00;
            tmr    <= '0;
            q1     <= '0;
            q10    <= '0;
            acnt   <= '0;
            bcnt   <= '0;
            fail   <= 1'b0;
            drv    <= 4'b0000;
            duty   <= '0;
            done   <= 1'b1;
            st_out <= 3'd0;
        end else begin
            state  <= state_nxt;
            ret    <= ret_nxt;
            en_sr  <= {en_sr[0], bus.Enable};
            tmr    <= tmr_nxt;
            q1     <= q1_nxt;
            q10    <= q10_nxt;
            acnt   <= acnt_nxt;
            bcnt   <= bcnt_nxt;
            fail   <= fail_nxt;
            drv    <= drv_nxt;
            duty   <= duty_nxt;
            done   <= (state == IDLE) || (state == DONE);
            st_out <= state;
        end
    end

    always_comb begin
        state_nxt = state;
        ret_nxt   = ret;
        tmr_nxt   = tmr;
        q1_nxt    = q1;
        q10_nxt   = q10;
        acnt_nxt  = acnt;
        bcnt_nxt  = bcnt;
        fail_nxt  = fail;
        tmr_inc   = tmr + 1'b1;
        q1_inc    = bus.IR_1k  ? q1 + 1'b1  : '0;
        q10_inc   = bus.IR_10k ? q10 + 1'b1 : '0;
        case (state)
            IDLE, DONE: begin
                if (rise) begin
                    state_nxt = SEARCH;
                    tmr_nxt   = '0;
                    q1_nxt    = '0;
                    q10_nxt   = '0;
                    acnt_nxt  = '0;
                    bcnt_nxt  = '0;
                    fail_nxt  = 1'b0;
                end
            end
            default: begin
                if (!bus.Enable) begin
                    state_nxt = IDLE;
                    tmr_nxt   = '0;
                    q1_nxt    = '0;
                    q10_nxt   = '0;
                    acnt_nxt  = '0;
                    bcnt_nxt  = '0;
                end else if (state == PAUSE) begin
                    // Counters hold; resume wherever we left off.
                    if (!bus.Pause) state_nxt = ret;
                end else if (bus.Pause) begin
                    state_nxt = PAUSE;
                    ret_nxt   = state;
                end else if (bus.Inductance && state != BACKOFF) begin
                    state_nxt = BACKOFF;
                    bcnt_nxt  = '0;
                    acnt_nxt  = '0;
                    ret_nxt   = SEARCH;
                end else begin
                    case (state)
                        SEARCH: begin
                            tmr_nxt = tmr_inc;
                            q1_nxt  = q1_inc;
                            q10_nxt = q10_inc;
                            if (tmr_inc == TMR_LIMIT) begin
                                state_nxt = IDLE;
                                fail_nxt  = 1'b1;
                            end else if (q1_inc == QUAL_LIMIT) begin
                                state_nxt = ALIGN_R;
                                acnt_nxt  = '0;
                            end else if (q10_inc == QUAL_LIMIT) begin
                                state_nxt = ALIGN_L;
                                acnt_nxt  = '0;
                            end
                        end
                        ALIGN_R, ALIGN_L: begin
                            if (acnt == ALIGN_LAST) state_nxt = DONE;
                            else                    acnt_nxt  = acnt + 1'b1;
                        end
                        BACKOFF: begin
                            // Count parks at the minimum while the wire is still seen.
                            if (bcnt == BACK_MIN && !bus.Inductance) begin
                                state_nxt = SEARCH;
                                q1_nxt    = '0;
                                q10_nxt   = '0;
                            end else if (bcnt != BACK_MIN) begin
                                bcnt_nxt = bcnt + 1'b1;
                            end
                        end
                        default: state_nxt = IDLE;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        drv_nxt  = 4'b0000;
        duty_nxt = '0;
        case (state)
            SEARCH:  begin drv_nxt = DRV_SRCH; duty_nxt = DUTY_W'(DUTY_SEARCH); end
            ALIGN_R: begin drv_nxt = DRV_R;    duty_nxt = DUTY_W'(DUTY_ALIGN);  end
            ALIGN_L: begin drv_nxt = DRV_L;    duty_nxt = DUTY_W'(DUTY_ALIGN);  end
            BACKOFF: begin drv_nxt = DRV_BACK; duty_nxt = DUTY_W'(DUTY_BACK);   end
            default: ;
        endcase
    end

    assign {bus.FWD_A, bus.FWD_B, bus.BWD_A, bus.BWD_B} = drv;
    assign bus.Duty_SelA = duty;
    assign bus.Duty_SelB = duty;
    assign bus.Done      = done;
    assign bus.Fail      = fail;
    assign bus.State     = st_out;
endmodule

// File: tb/tb_goal_seek_ctrl.sv
// Scoreboard bench for goal_seek_ctrl: each scenario queues per-cycle expected
// output words and pops/compares them as the cycles elapse.
module tb_goal_seek_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    goal_seek_if #(.DUTY_W(2)) bus ();

    goal_seek_ctrl #(
        .DUTY_W(2), .CNT_W(30), .ALIGN_CYCLES(10), .BACKOFF_CYCLES(20),
        .SEARCH_TIMEOUT(100), .QUAL_CYCLES(3), .SEARCH_DIR(1'b0),
        .DUTY_SEARCH(0), .DUTY_ALIGN(2), .DUTY_BACK(3)
    ) dut (
        .clk(clk),
        .Reset(rst),
        .bus(bus)
    );

    typedef struct {
        int          cyc;
        string       name;
        logic [12:0] val;
    } exp_t;

    exp_t sb[$];
    logic [12:0] obs;
    assign obs = {bus.State, bus.FWD_A, bus.FWD_B, bus.BWD_A, bus.BWD_B,
                  bus.Duty_SelA, bus.Duty_SelB, bus.Done, bus.Fail};

    function automatic logic [12:0] ew(input logic [2:0] st, input logic [3:0] drv,
                                       input logic [1:0] duty, input logic dn, input logic fl);
        return {st, drv, duty, duty, dn, fl};
    endfunction

    task automatic expect_rng(input int lo, input int hi, input string nm, input logic [12:0] v);
        for (int c = lo; c <= hi; c++) sb.push_back('{c, nm, v});
    endtask

    task automatic drive(input logic en, input logic ps, input logic ind,
                         input logic ir1, input logic ir10);
        bus.Enable = en; bus.Pause = ps; bus.Inductance = ind;
        bus.IR_1k = ir1; bus.IR_10k = ir10;
    endtask

    task automatic preamble(output int base);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        base = cyc;
    endtask

    task automatic test_reset();
        exp_t e;
        int base;
        base = cyc;
        expect_rng(base + 2, base + 6, "reset_idle", ew(3'd0, 4'b0000, 2'd0, 1'b1, 1'b0));
        for (int i = 0; i < 6; i++) begin
            rst = (i < 3);
            drive(0, 0, 0, 0, 0);
            @(posedge clk);
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, e.cyc - base, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_align_right();
        exp_t e;
        int base;
        preamble(base);
        expect_rng(base + 3,  base + 7,  "ar_search", ew(3'd1, 4'b1001, 2'd0, 1'b0, 1'b0));
        expect_rng(base + 8,  base + 17, "ar_align",  ew(3'd2, 4'b1001, 2'd2, 1'b0, 1'b0));
        expect_rng(base + 18, base + 20, "ar_done",   ew(3'd6, 4'b0000, 2'd0, 1'b1, 1'b0));
        for (int i = 0; i < 21; i++) begin
            drive(1, 0, 0, (i >= 4 && i <= 6), 0);
            @(posedge clk);
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, e.cyc - base, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_align_left_qual();
        exp_t e;
        int base;
        preamble(base);
        expect_rng(base + 3,  base + 14, "al_search", ew(3'd1, 4'b1001, 2'd0, 1'b0, 1'b0));
        expect_rng(base + 15, base + 17, "al_align",  ew(3'd3, 4'b0110, 2'd2, 1'b0, 1'b0));
        for (int i = 0; i < 18; i++) begin
            drive(1, 0, 0, 0, (i == 4 || i == 5 || i == 8 || i == 9 || i >= 11));
            @(posedge clk);
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, e.cyc - base, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_both_ir();
        exp_t e;
        int base;
        preamble(base);
        expect_rng(base + 7, base + 7,  "both_search", ew(3'd1, 4'b1001, 2'd0, 1'b0, 1'b0));
        expect_rng(base + 8, base + 10, "both_right",  ew(3'd2, 4'b1001, 2'd2, 1'b0, 1'b0));
        for (int i = 0; i < 11; i++) begin
            drive(1, 0, 0, (i >= 4), (i >= 4));
            @(posedge clk);
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, e.cyc - base, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_pause();
        exp_t e;
        int base;
        preamble(base);
        expect_rng(base + 3,  base + 7,  "ps_search", ew(3'd1, 4'b1001, 2'd0, 1'b0, 1'b0));
        expect_rng(base + 8,  base + 12, "ps_align0", ew(3'd2, 4'b1001, 2'd2, 1'b0, 1'b0));
        expect_rng(base + 13, base + 19, "ps_pause",  ew(3'd4, 4'b0000, 2'd0, 1'b0, 1'b0));
        expect_rng(base + 20, base + 25, "ps_align1", ew(3'd2, 4'b1001, 2'd2, 1'b0, 1'b0));
        expect_rng(base + 26, base + 27, "ps_done",   ew(3'd6, 4'b0000, 2'd0, 1'b1, 1'b0));
        for (int i = 0; i < 28; i++) begin
            drive(1, (i >= 11 && i <= 17), 0, (i >= 4 && i <= 6), 0);
            @(posedge clk);
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, e.cyc - base, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_backoff();
        exp_t e;
        int base;
        preamble(base);
        expect_rng(base + 3,  base + 7,  "bo_search0", ew(3'd1, 4'b1001, 2'd0, 1'b0, 1'b0));
        expect_rng(base + 8,  base + 13, "bo_align0",  ew(3'd2, 4'b1001, 2'd2, 1'b0, 1'b0));
        expect_rng(base + 14, base + 43, "bo_back",    ew(3'd5, 4'b0011, 2'd3, 1'b0, 1'b0));
        expect_rng(base + 44, base + 48, "bo_search1", ew(3'd1, 4'b1001, 2'd0, 1'b0, 1'b0));
        expect_rng(base + 49, base + 50, "bo_align1",  ew(3'd2, 4'b1001, 2'd2, 1'b0, 1'b0));
        for (int i = 0; i < 51; i++) begin
            drive(1, 0, (i >= 12 && i <= 41), ((i >= 4 && i <= 6) || (i >= 45 && i <= 47)), 0);
            @(posedge clk);
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, e.cyc - base, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_backoff_min();
        exp_t e;
        int base;
        preamble(base);
        expect_rng(base + 3,  base + 6,  "bm_search0", ew(3'd1, 4'b1001, 2'd0, 1'b0, 1'b0));
        expect_rng(base + 7,  base + 27, "bm_back",    ew(3'd5, 4'b0011, 2'd3, 1'b0, 1'b0));
        expect_rng(base + 28, base + 29, "bm_search1", ew(3'd1, 4'b1001, 2'd0, 1'b0, 1'b0));
        for (int i = 0; i < 30; i++) begin
            drive(1, 0, (i == 5), 0, 0);
            @(posedge clk);
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, e.cyc - base, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_timeout_restart_abort();
        exp_t e;
        int base;
        logic en;
        preamble(base);
        expect_rng(base + 3,   base + 101, "to_search",   ew(3'd1, 4'b1001, 2'd0, 1'b0, 1'b0));
        expect_rng(base + 102, base + 102, "to_failset",  ew(3'd1, 4'b1001, 2'd0, 1'b0, 1'b1));
        expect_rng(base + 103, base + 107, "to_idlefail", ew(3'd0, 4'b0000, 2'd0, 1'b1, 1'b1));
        expect_rng(base + 108, base + 108, "to_failclr",  ew(3'd0, 4'b0000, 2'd0, 1'b1, 1'b0));
        expect_rng(base + 109, base + 113, "to_research", ew(3'd1, 4'b1001, 2'd0, 1'b0, 1'b0));
        expect_rng(base + 114, base + 115, "to_abort",    ew(3'd0, 4'b0000, 2'd0, 1'b1, 1'b0));
        for (int i = 0; i < 116; i++) begin
            en = (i < 104) || (i >= 106 && i < 112);
            drive(en, 0, 0, 0, 0);
            @(posedge clk);
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, e.cyc - base, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_reset_mid_backoff();
        exp_t e;
        int base;
        preamble(base);
        expect_rng(base + 6,  base + 10, "rm_back", ew(3'd5, 4'b0011, 2'd3, 1'b0, 1'b0));
        expect_rng(base + 12, base + 14, "rm_idle", ew(3'd0, 4'b0000, 2'd0, 1'b1, 1'b0));
        for (int i = 0; i < 14; i++) begin
            rst = (i == 10);
            drive((i < 10), 0, (i >= 4 && i <= 9), 0, 0);
            @(posedge clk);
            @(negedge clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total++;
                if (obs !== e.val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h expected=%h", e.name, e.cyc - base, obs, e.val);
                end
            end
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        test_reset();
        test_align_right();
        test_align_left_qual();
        test_both_ir();
        test_pause();
        test_backoff();
        test_backoff_min();
        test_timeout_restart_abort();
        test_reset_mid_backoff();
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
